z_writeback_unit: RTL and testbench
===================================

Name: z_writeback_unit

Overview:
- Consumer end of the ALU result path.
- Accepts one 64-bit ALU result plus its opcode and destination through a valid/ready handshake.
- Serialises the result onto the 32-bit datapath bus as one or two write beats: LO/HI for multiply/divide, a single GPR write for all other ops.
- Sits between the ALU/Z register and the register-file/HI-LO write ports; frees the ALU for the next operation as soon as the result is captured.

Parameters:
- DATA_W, 32, bus word width; result width is 2*DATA_W.
- REG_SEL_W, 4, width of the GPR destination index.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset.
- res_valid  in  1  ALU result is present.
- res_ready  out  1  unit can capture a result.
- res_opcode  in  5  opcode that produced the result.
- res_data  in  64  ALU result; [31:0] low word, [63:32] high word.
- res_dest  in  REG_SEL_W  destination GPR index; ignored for mul/div.
- bus_data  out  32  write data.
- bus_valid  out  1  write beat pending.
- bus_ready  in  1  write port accepts the beat.
- wr_gpr  out  1  beat targets GPR wr_sel.
- wr_lo  out  1  beat targets LO.
- wr_hi  out  1  beat targets HI.
- wr_sel  out  REG_SEL_W  captured destination index.
- done  out  1  one-cycle pulse after the final beat.
- err  out  1  one-cycle pulse for an unsupported opcode.

Behaviour:
- Reset: on clear=1, at the next edge:
  - state=IDLE
  - res_ready=1
  - bus_valid, wr_gpr, wr_lo, wr_hi, done, err = 0
  - bus_data=0, wr_sel=0
  - capture registers cleared
- clear wins over every other event. A beat in flight when clear asserts is dropped and no done is issued.
- States: IDLE, BEAT_LO, BEAT_HI, BEAT_GPR, FIN.
- IDLE:
  - res_ready=1.
  - Capture occurs on res_valid&&res_ready: latch res_opcode, res_data and res_dest; res_ready drops on the next cycle.
- Opcode decode at capture:
  - MUL 5'b01111 or DIV 5'b10000 -> BEAT_LO.
  - AND 00101, OR 00110, ADD 00011, SUB 00100, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, NEG 10001, NOT 10010 -> BEAT_GPR.
  - Any other opcode -> FIN with err=1 for one cycle; no beat is issued.
- BEAT_LO:
  - bus_valid=1, wr_lo=1, bus_data=cap[31:0].
  - For DIV this word is the quotient.
  - On bus_ready -> BEAT_HI.
- BEAT_HI:
  - bus_valid=1, wr_hi=1, bus_data=cap[63:32].
  - For DIV this word is the remainder.
  - On bus_ready -> FIN.
- BEAT_GPR:
  - bus_valid=1, wr_gpr=1, wr_sel=cap_dest, bus_data=cap[31:0].
  - The upper word is discarded.
  - On bus_ready -> FIN.
- Beat stall: while bus_ready=0, bus_valid, bus_data and the wr_* strobes hold stable; no timeout.
- FIN:
  - done=1 for exactly one cycle (also after err).
  - -> IDLE, with res_ready=1 on the following cycle.
- Strobe exclusivity: exactly one wr_* strobe is high whenever bus_valid=1; all are low otherwise.
- Latency with bus_ready tied high, capture at edge N:
  - GPR op: beat during N..N+1, done during N+2.
  - MUL/DIV: LO during N+1, HI during N+2, done during N+3.
- Back-to-back: no new capture before IDLE. Minimum issue interval is 3 cycles (GPR op) or 4 cycles (MUL/DIV).
- res_data changing after capture has no effect.

Optional Feature:
- Macro ZWB_FLAGS_EN.
- When defined:
  - Extra outputs flag_z (1) and flag_n (1), registered at capture.
  - MUL/DIV: flag_z = (cap[63:0]==0), flag_n = cap[63].
  - Other ops: flag_z = (cap[31:0]==0), flag_n = cap[31].
  - Flags hold until the next capture; clear sets both to 0.
- When undefined: the ports are absent and no flag logic is built.

Decomposition:
- Package alu_pkg:
  - 5-bit opcode localparams, shared with the ALU.
  - State encoding for IDLE/BEAT_LO/BEAT_HI/BEAT_GPR/FIN.
  - DATA_W default.
- Sub-module zwb_flags: combinational flag compute, instantiated only under ZWB_FLAGS_EN.
- FSM and beat registers remain in the top module.

Test Plan:
- ADD, res_data=64'h0000_0000_0000_0005, res_dest=4'd3, bus_ready=1 -> one beat: wr_gpr=1, wr_sel=3, bus_data=32'h5; done two cycles after capture; wr_lo and wr_hi never assert.
- MUL, res_data=64'h0000_0001_8000_0000 -> LO beat 32'h8000_0000, then HI beat 32'h0000_0001 on consecutive cycles; done on the third cycle after capture.
- DIV, quotient 7 and remainder 2, bus_ready low for 3 cycles on the LO beat -> bus_data=7 and wr_lo held stable through the stall; HI=2 follows once bus_ready=1.
- Opcode 5'b11111 -> err and done pulse with no beat; res_ready returns high 2 cycles after capture.
- clear asserted during BEAT_HI -> next edge gives IDLE with all outputs at reset values and no done; a subsequent ADD completes normally.
- Under ZWB_FLAGS_EN: NEG result 32'hFFFF_FFFB -> flag_n=1, flag_z=0; MUL result 64'h0 -> flag_z=1.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcodes shared with the ALU, writeback state encoding, defaults
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int REG_SEL_W_DEF = 4;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BEAT_LO  = 3'd1,
    ST_BEAT_HI  = 3'd2,
    ST_BEAT_GPR = 3'd3,
    ST_FIN      = 3'd4
  } zwb_state_e;

  // Mul/div produce a double-width result written to LO then HI.
  function automatic logic is_wide_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_gpr_op(input logic [4:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SHR, OP_SHRA,
      OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT: hit = 1'b1;
      default:                                hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/z_writeback_unit_if.sv
// ============================================================================
// z_writeback_unit_if : ALU result handshake and register write-beat bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface z_writeback_unit_if #(
  parameter int DATA_W    = 32,
  parameter int REG_SEL_W = 4
);
  logic                   res_valid;
  logic                   res_ready;
  logic [4:0]             res_opcode;
  logic [2*DATA_W-1:0]    res_data;
  logic [REG_SEL_W-1:0]   res_dest;
  logic [DATA_W-1:0]      bus_data;
  logic                   bus_valid;
  logic                   bus_ready;
  logic                   wr_gpr;
  logic                   wr_lo;
  logic                   wr_hi;
  logic [REG_SEL_W-1:0]   wr_sel;

  // Environment side: ALU producer and register-file write ports.
  modport master (
    output res_valid, res_opcode, res_data, res_dest, bus_ready,
    input  res_ready, bus_data, bus_valid, wr_gpr, wr_lo, wr_hi, wr_sel
  );

  // Writeback unit side.
  modport slave (
    input  res_valid, res_opcode, res_data, res_dest, bus_ready,
    output res_ready, bus_data, bus_valid, wr_gpr, wr_lo, wr_hi, wr_sel
  );
endinterface

`default_nettype wire

// File: rtl/zwb_flags.sv
// ============================================================================
// zwb_flags : zero/negative flags of an ALU result (full width for mul/div)
// Revision: 1.0
// ============================================================================
`default_nettype none

module zwb_flags #(
  parameter int DATA_W = 32
) (
  input  wire logic [2*DATA_W-1:0] data,
  input  wire logic                wide,
  output logic                     flag_z,
  output logic                     flag_n
);
  always_comb begin
    flag_z = 1'b0;
    flag_n = 1'b0;
    if (wide) begin
      flag_z = (data == '0);
      flag_n = data[2*DATA_W-1];
    end else begin
      flag_z = (data[DATA_W-1:0] == '0);
      flag_n = data[DATA_W-1];
    end
  end
endmodule

`default_nettype wire

// File: rtl/z_writeback_unit.sv
// ============================================================================
// z_writeback_unit : captures an ALU result and writes it as LO/HI or GPR beats
// Optional flag outputs flag_z/flag_n under macro ZWB_FLAGS_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module z_writeback_unit
  import alu_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_SEL_W = REG_SEL_W_DEF
) (
  input  wire logic         clock,
  input  wire logic         clear,
  z_writeback_unit_if.slave zif,
  output logic              done,
  output logic              err
`ifdef ZWB_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);

  zwb_state_e             state_q, state_d;
  logic [2*DATA_W-1:0]    cap_data_q, cap_data_d;
  logic [4:0]             cap_op_q, cap_op_d;
  logic [REG_SEL_W-1:0]   cap_dest_q, cap_dest_d;
  logic                   capture;

  assign capture = (state_q == ST_IDLE) && zif.res_valid;

`ifdef ZWB_FLAGS_EN
  logic flag_z_q, flag_z_d, flag_n_q, flag_n_d;
  logic new_z, new_n;

  // Flags are computed from the incoming result so they land with the capture.
  zwb_flags #(.DATA_W(DATA_W)) u_flags (
    .data   (zif.res_data),
    .wide   (is_wide_op(zif.res_opcode)),
    .flag_z (new_z),
    .flag_n (new_n)
  );

  always_comb begin
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    if (capture) begin
      flag_z_d = new_z;
      flag_n_d = new_n;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`endif

  always_comb begin
    state_d    = state_q;
    cap_data_d = cap_data_q;
    cap_op_d   = cap_op_q;
    cap_dest_d = cap_dest_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          cap_data_d = zif.res_data;
          cap_op_d   = zif.res_opcode;
          cap_dest_d = zif.res_dest;
          if (is_wide_op(zif.res_opcode))     state_d = ST_BEAT_LO;
          else if (is_gpr_op(zif.res_opcode)) state_d = ST_BEAT_GPR;
          else                                state_d = ST_FIN;
        end
      end
      ST_BEAT_LO:  if (zif.bus_ready) state_d = ST_BEAT_HI;
      ST_BEAT_HI:  if (zif.bus_ready) state_d = ST_FIN;
      ST_BEAT_GPR: if (zif.bus_ready) state_d = ST_FIN;
      ST_FIN:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      cap_data_q <= '0;
      cap_op_q   <= '0;
      cap_dest_q <= '0;
    end else begin
      state_q    <= state_d;
      cap_data_q <= cap_data_d;
      cap_op_q   <= cap_op_d;
      cap_dest_q <= cap_dest_d;
    end
  end

  // Outputs decode straight from registered state, so they hold during a stall.
  always_comb begin
    zif.res_ready = (state_q == ST_IDLE);
    zif.bus_valid = 1'b0;
    zif.wr_gpr    = 1'b0;
    zif.wr_lo     = 1'b0;
    zif.wr_hi     = 1'b0;
    zif.bus_data  = '0;
    zif.wr_sel    = cap_dest_q;
    done          = 1'b0;
    err           = 1'b0;
    case (state_q)
      ST_BEAT_LO: begin
        zif.bus_valid = 1'b1;
        zif.wr_lo     = 1'b1;
        zif.bus_data  = cap_data_q[DATA_W-1:0];
      end
      ST_BEAT_HI: begin
        zif.bus_valid = 1'b1;
        zif.wr_hi     = 1'b1;
        zif.bus_data  = cap_data_q[2*DATA_W-1:DATA_W];
      end
      ST_BEAT_GPR: begin
        zif.bus_valid = 1'b1;
        zif.wr_gpr    = 1'b1;
        zif.bus_data  = cap_data_q[DATA_W-1:0];
      end
      ST_FIN: begin
        done = 1'b1;
        err  = !is_wide_op(cap_op_q) && !is_gpr_op(cap_op_q);
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_z_writeback_unit.sv
// ============================================================================
// tb_z_writeback_unit : directed vectors and corner sequences for z_writeback_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_z_writeback_unit;

  logic clk = 1'b0;
  logic clear;
  logic done, err;
`ifdef ZWB_FLAGS_EN
  logic flag_z, flag_n;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  z_writeback_unit_if #(.DATA_W(32), .REG_SEL_W(4)) zif ();

  z_writeback_unit #(.DATA_W(32), .REG_SEL_W(4)) dut (
    .clock  (clk),
    .clear  (clear),
    .zif    (zif),
    .done   (done),
    .err    (err)
`ifdef ZWB_FLAGS_EN
    ,
    .flag_z (flag_z),
    .flag_n (flag_n)
`endif
  );

  // kind: 0 = single GPR beat, 1 = LO/HI pair, 2 = unsupported opcode
  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [63:0] data;
    logic [3:0]  dest;
    int          kind;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_z;
    logic        exp_n;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic v, input logic g,
                            input logic lo, input logic hi, input logic [31:0] d);
    check({tag, "_bus_valid"}, {63'd0, zif.bus_valid}, {63'd0, v});
    check({tag, "_wr_gpr"},    {63'd0, zif.wr_gpr},    {63'd0, g});
    check({tag, "_wr_lo"},     {63'd0, zif.wr_lo},     {63'd0, lo});
    check({tag, "_wr_hi"},     {63'd0, zif.wr_hi},     {63'd0, hi});
    check({tag, "_bus_data"},  {32'd0, zif.bus_data},  {32'd0, d});
  endtask

  task automatic run_vec(input vec_t v);
    zif.res_valid  = 1'b1;
    zif.res_opcode = v.op;
    zif.res_data   = v.data;
    zif.res_dest   = v.dest;
    check({v.name, "_ready_idle"}, {63'd0, zif.res_ready}, 64'd1);
    tick();
    zif.res_valid  = 1'b0;
    zif.res_opcode = 5'b00000;
    zif.res_data   = ~v.data;
    zif.res_dest   = ~v.dest;
    check({v.name, "_ready_busy"}, {63'd0, zif.res_ready}, 64'd0);
`ifdef ZWB_FLAGS_EN
    if (v.kind != 2) begin
      check({v.name, "_flag_z"}, {63'd0, flag_z}, {63'd0, v.exp_z});
      check({v.name, "_flag_n"}, {63'd0, flag_n}, {63'd0, v.exp_n});
    end
`endif
    case (v.kind)
      0: begin
        check_beat({v.name, "_gpr"}, 1'b1, 1'b1, 1'b0, 1'b0, v.exp_lo);
        check({v.name, "_wr_sel"}, {60'd0, zif.wr_sel}, {60'd0, v.dest});
        check({v.name, "_early_done"}, {63'd0, done}, 64'd0);
        tick();
      end
      1: begin
        check_beat({v.name, "_lo"}, 1'b1, 1'b0, 1'b1, 1'b0, v.exp_lo);
        tick();
        check_beat({v.name, "_hi"}, 1'b1, 1'b0, 1'b0, 1'b1, v.exp_hi);
        check({v.name, "_early_done"}, {63'd0, done}, 64'd0);
        tick();
      end
      default: begin
        check_beat({v.name, "_nobeat"}, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      end
    endcase
    check({v.name, "_done"}, {63'd0, done}, 64'd1);
    check({v.name, "_err"},  {63'd0, err},  {63'd0, (v.kind == 2)});
    check({v.name, "_fin_idle_bus"}, {63'd0, zif.bus_valid}, 64'd0);
    tick();
    check({v.name, "_ready_back"}, {63'd0, zif.res_ready}, 64'd1);
    check({v.name, "_done_pulse"}, {63'd0, done}, 64'd0);
    check({v.name, "_err_pulse"},  {63'd0, err},  64'd0);
  endtask

  initial begin
    vecs[0] = '{"add",   5'b00011, 64'h0000_0000_0000_0005, 4'd3,  0, 32'h0000_0005, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{"mul",   5'b01111, 64'h0000_0001_8000_0000, 4'd7,  1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0};
    vecs[2] = '{"neg",   5'b10001, 64'hDEAD_BEEF_FFFF_FFFB, 4'd15, 0, 32'hFFFF_FFFB, 32'h0, 1'b0, 1'b1};
    vecs[3] = '{"div",   5'b10000, 64'h0000_0002_0000_0007, 4'd1,  1, 32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0};
    vecs[4] = '{"mul0",  5'b01111, 64'h0000_0000_0000_0000, 4'd2,  1, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[5] = '{"sub0",  5'b00100, 64'hFFFF_FFFF_0000_0000, 4'd9,  0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[6] = '{"bad1f", 5'b11111, 64'h1234_5678_9ABC_DEF0, 4'd4,  2, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[7] = '{"bad00", 5'b00000, 64'h0000_0000_0000_0001, 4'd5,  2, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[8] = '{"not",   5'b10010, 64'h0000_0000_8000_0001, 4'd0,  0, 32'h8000_0001, 32'h0, 1'b0, 1'b1};

    clear          = 1'b1;
    zif.res_valid  = 1'b0;
    zif.res_opcode = 5'd0;
    zif.res_data   = 64'd0;
    zif.res_dest   = 4'd0;
    zif.bus_ready  = 1'b1;
    tick();
    tick();
    check("rst_ready", {63'd0, zif.res_ready}, 64'd1);
    check_beat("rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("rst_wr_sel", {60'd0, zif.wr_sel}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err",  {63'd0, err},  64'd0);
    clear = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // DIV with LO beat stalled three cycles
    zif.res_valid  = 1'b1;
    zif.res_opcode = 5'b10000;
    zif.res_data   = 64'h0000_0002_0000_0007;
    zif.res_dest   = 4'd6;
    zif.bus_ready  = 1'b0;
    tick();
    zif.res_valid = 1'b0;
    zif.res_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      check_beat("stall_lo", 1'b1, 1'b0, 1'b1, 1'b0, 32'd7);
      tick();
    end
    zif.bus_ready = 1'b1;
    check_beat("stall_lo_rel", 1'b1, 1'b0, 1'b1, 1'b0, 32'd7);
    tick();
    check_beat("stall_hi", 1'b1, 1'b0, 1'b0, 1'b1, 32'd2);
    tick();
    check("stall_done", {63'd0, done}, 64'd1);
    tick();
    check("stall_ready", {63'd0, zif.res_ready}, 64'd1);

    // clear during BEAT_HI drops the beat with no done
    zif.res_valid  = 1'b1;
    zif.res_opcode = 5'b01111;
    zif.res_data   = 64'hAAAA_AAAA_5555_5555;
    zif.res_dest   = 4'd8;
    tick();
    zif.res_valid = 1'b0;
    check_beat("clr_lo", 1'b1, 1'b0, 1'b1, 1'b0, 32'h5555_5555);
    tick();
    check_beat("clr_hi", 1'b1, 1'b0, 1'b0, 1'b1, 32'hAAAA_AAAA);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_beat("clr_after", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("clr_ready", {63'd0, zif.res_ready}, 64'd1);
    check("clr_wr_sel", {60'd0, zif.wr_sel}, 64'd0);
    check("clr_done", {63'd0, done}, 64'd0);
    tick();
    check("clr_no_done", {63'd0, done}, 64'd0);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
